// File: rtl/rr_mux_reg_if.sv
// Handshake bundle for rr_mux_reg: N producer channels in, one registered consumer channel out.
// The slave modport is the mux side; the master modport is the producer/consumer side.
interface rr_mux_reg_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/rr_mux_reg.sv
// Registered N-to-1 mux with an internal fixed-priority or round-robin arbiter and a
// single full-throughput valid/ready output stage.
module rr_mux_reg #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter bit RR    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_mux_reg_if.slave bus
);
  localparam int SELW = $clog2(N);
  localparam logic [SELW:0]   N_EXT = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST  = SELW'(N-1);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_nxt;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  sel_q;
  logic             valid_q;

  logic [N-1:0]     grant;
  logic [SELW-1:0]  gidx;
  logic             any_valid;
  logic [SELW:0]    idx;
  logic [WIDTH-1:0] sel_data;
  logic             load;

  assign load = !valid_q || bus.out_ready;

  // Search starts at ptr and wraps modulo N; with RR=0 ptr stays 0 so this is lowest-index-wins.
  always_comb begin
    grant     = '0;
    gidx      = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (SELW+1)'(k);
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (!any_valid && bus.in_valid[idx[SELW-1:0]]) begin
        any_valid                = 1'b1;
        grant[idx[SELW-1:0]]     = 1'b1;
        gidx                     = idx[SELW-1:0];
      end
    end
  end

  always_comb begin
    sel_data = bus.in_data[int'(gidx)*WIDTH +: WIDTH];
    ptr_nxt  = (gidx == LAST) ? '0 : gidx + 1'b1;
  end

  // Reset gates in_ready so no producer sees an acceptance while the stage is held in reset.
  assign bus.in_ready  = (load && rst_n) ? grant : '0;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr     <= '0;
    end else if (load) begin
      if (any_valid) begin
        data_q  <= sel_data;
        sel_q   <= gidx;
        valid_q <= 1'b1;
        if (RR) ptr <= ptr_nxt;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: doc/rr_mux_reg.md
# rr_mux_reg

Registered, parametrised N-input, WIDTH-bit multiplexer with built-in arbitration and valid/ready handshake. It extends the basic select-line multiplexer: the select is computed internally each cycle by a fixed-priority or round-robin arbiter instead of being driven externally. It sits between multiple data producers (e.g. register-file read ports, fetch/load sources) and a single consumer on the CPU datapath. The output is a single registered stage with full throughput.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- N, 4, number of input channels (≥2)
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins)
- SELW, $clog2(N), width of out_sel (derived, not overridden)

- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  channel i presents data
- in_ready  output  N  channel i transfer accepted this cycle (at most one bit set)
- out_data  output  WIDTH  registered selected data
- out_valid  output  1  out_data holds an untaken word
- out_sel  output  SELW  index of the channel that produced out_data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Transfer on input i: in_valid[i] && in_ready[i] at a rising edge. Transfer on output: out_valid && out_ready.
- load = !out_valid || out_ready (output register empty or being drained this cycle).
- Grant: one-hot vector computed combinationally from in_valid and the priority pointer ptr.
  - RR=0: lowest-index asserted in_valid wins; ptr is unused and held at 0.
  - RR=1: search starts at index ptr, ascending, wrapping N-1 -> 0; first asserted in_valid wins.
- in_ready[i] = load && grant[i]. in_ready depends combinationally on out_ready and in_valid. No in_ready bit is asserted when no in_valid is asserted.
- On an input transfer from channel g:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - RR=1: ptr <= (g == N-1) ? 0 : g+1
- If load is true and no channel is valid, out_valid <= 0. out_data and out_sel hold their previous values and are don't-care.
- If load is false, all registers hold, including ptr. A stalled word is never overwritten or dropped.
- ptr advances only on an actual input transfer, never on idle or stalled cycles.
- Data is passed through bit-exact. There is no arithmetic on data; ptr arithmetic is modulo N, including non-power-of-2 N.

## Timing
- Reset (async assert, sync-safe deassert by system): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is all zeros while rst_n=0.
- Latency: input transfer at edge k gives out_valid=1 with that word during cycle k+1.
- Throughput: one word per cycle when out_ready is held 1 and any in_valid is asserted.
- Simultaneous requests: exactly one grant per cycle; losing channels see in_ready=0 and must hold their data.
- Simultaneous drain and load: an output transfer and an input transfer in the same cycle are legal; the new word replaces the old with no bubble.
- Back-pressure: with out_valid=1 and out_ready=0, in_ready is all zeros and out_data/out_sel are stable until taken.
- Reset mid-operation: any pending output word is discarded and ptr returns to 0 immediately (asynchronous). The first grant after reset follows the ptr=0 rules.
- Producers may deassert in_valid without a transfer; the arbiter re-evaluates every cycle, with no lock-in.

## Test plan
- Reset: assert rst_n=0 during traffic with out_valid=1 -> out_valid, out_data, out_sel and in_ready go to 0 without a clock edge; first grant after release goes to channel 0 when all are valid.
- Round-robin fairness (N=4, WIDTH=8, RR=1): all in_valid=1, data 8'hA0..8'hA3, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, out_data matching each.
- Fixed priority (RR=0): in_valid=4'b1010 held, out_ready=1 -> every cycle out_sel=1, in_ready=4'b0010; drop in_valid[1] -> out_sel=3.
- Back-pressure: out_valid=1 with 8'h55 from channel 2, out_ready=0 for 5 cycles with all inputs valid -> in_ready=0, out_data=8'h55 and out_sel=2 stable, ptr unchanged; raise out_ready -> next grant goes to channel 3.
- Wrap and non-power-of-2 (N=3, RR=1): only channel 2 valid, then all valid -> grants 2, then 0,1,2; ptr never reaches 3.
- Idle gap: single transfer followed by in_valid=0 with out_ready=1 -> out_valid 1 for exactly one cycle, then 0; ptr is held across the idle cycles.
